// File: rtl/card_disp_pkg.sv
// Shared definitions for the seven-segment card display interface: segment
// patterns, card rank type, card value and score reduction helpers.
package card_disp_pkg;

   typedef logic [3:0] card_rank_t;

   localparam card_rank_t RANK_BLANK   = 4'd0;
   localparam card_rank_t RANK_ILLEGAL = 4'd15;

   // Active-low segments, bit6..0 = g..a
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_ACE   = 7'b0001000;
   localparam logic [6:0] SEG_TWO   = 7'b0100100;
   localparam logic [6:0] SEG_THREE = 7'b0110000;
   localparam logic [6:0] SEG_FOUR  = 7'b0011001;
   localparam logic [6:0] SEG_FIVE  = 7'b0010010;
   localparam logic [6:0] SEG_SIX   = 7'b0000010;
   localparam logic [6:0] SEG_SEVEN = 7'b1111000;
   localparam logic [6:0] SEG_EIGHT = 7'b0000000;
   localparam logic [6:0] SEG_NINE  = 7'b0010000;
   localparam logic [6:0] SEG_TEN   = 7'b1000000;
   localparam logic [6:0] SEG_JACK  = 7'b1100001;
   localparam logic [6:0] SEG_QUEEN = 7'b0011000;
   localparam logic [6:0] SEG_KING  = 7'b1001001;

   typedef enum logic [1:0] {
      ST_SETTLE,
      ST_EVAL,
      ST_HOLD
   } mon_state_t;

   typedef struct packed {
      logic [5:0][3:0] cards;
      logic [3:0]      pscore;
      logic [3:0]      dscore;
      logic            pwin;
      logic            dwin;
      logic            bad;
      logic            mismatch;
   } mon_result_t;

   function automatic logic [3:0] card_value(input card_rank_t rank);
      if (rank >= 4'd1 && rank <= 4'd9) begin
         return rank;
      end
      return 4'd0;
   endfunction

   function automatic logic [3:0] mod10(input logic [4:0] sum);
      if (sum >= 5'd20) begin
         return 4'(sum - 5'd20);
      end else if (sum >= 5'd10) begin
         return 4'(sum - 5'd10);
      end
      return sum[3:0];
   endfunction

endpackage

// File: rtl/seg_to_rank.sv
// Decodes one active-low seven-segment card pattern back to a card rank.
module seg_to_rank
   import card_disp_pkg::*;
(
   input  logic [6:0] seg,
   output card_rank_t rank
);

   always_comb begin
      rank = RANK_ILLEGAL;
      case (seg)
         SEG_BLANK: rank = RANK_BLANK;
         SEG_ACE:   rank = 4'd1;
         SEG_TWO:   rank = 4'd2;
         SEG_THREE: rank = 4'd3;
         SEG_FOUR:  rank = 4'd4;
         SEG_FIVE:  rank = 4'd5;
         SEG_SIX:   rank = 4'd6;
         SEG_SEVEN: rank = 4'd7;
         SEG_EIGHT: rank = 4'd8;
         SEG_NINE:  rank = 4'd9;
         SEG_TEN:   rank = 4'd10;
         SEG_JACK:  rank = 4'd11;
         SEG_QUEEN: rank = 4'd12;
         SEG_KING:  rank = 4'd13;
         default:   rank = RANK_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/hex_card_monitor.sv
// Monitors the baccarat card displays and LEDR, recomputes scores/winner once
// inputs settle and flags disagreement. Optional counters: HEX_MONITOR_COUNT_EN.
module hex_card_monitor
   import card_disp_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [6:0] HEX0,
   input  logic [6:0] HEX1,
   input  logic [6:0] HEX2,
   input  logic [6:0] HEX3,
   input  logic [6:0] HEX4,
   input  logic [6:0] HEX5,
   input  logic [9:0] LEDR,
   output logic [3:0] p_card1,
   output logic [3:0] p_card2,
   output logic [3:0] p_card3,
   output logic [3:0] d_card1,
   output logic [3:0] d_card2,
   output logic [3:0] d_card3,
   output logic [3:0] player_score,
   output logic [3:0] dealer_score,
   output logic       player_win,
   output logic       dealer_win,
   output logic       result_valid,
   output logic       bad_pattern,
   output logic       score_mismatch,
   output logic [7:0] hand_count,
   output logic [7:0] mismatch_count
);

   localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

   logic [51:0]     in_vec;
   logic [51:0]     snap_q, snap_d;
   logic [7:0]      cnt_q, cnt_d;
   mon_state_t      state_q, state_d;
   mon_result_t     res_q, res_d, eval_res;
   logic            valid_q, valid_d;
   logic [5:0][3:0] ranks;
   logic            changed;
   logic            all_blank;
   logic [4:0]      p_sum, d_sum;
   logic [9:0]      snap_ledr;

   assign in_vec    = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0, LEDR};
   assign changed   = (in_vec != snap_q);
   assign snap_ledr = snap_q[9:0];

   for (genvar i = 0; i < 6; i++) begin : g_dec
      seg_to_rank u_dec (
         .seg  (snap_q[10 + 7*i +: 7]),
         .rank (ranks[i])
      );
   end

   always_comb begin
      eval_res       = '0;
      p_sum          = 5'(card_value(ranks[0])) + 5'(card_value(ranks[1]))
                     + 5'(card_value(ranks[2]));
      d_sum          = 5'(card_value(ranks[3])) + 5'(card_value(ranks[4]))
                     + 5'(card_value(ranks[5]));
      all_blank      = (ranks == '0);
      eval_res.cards = ranks;
      eval_res.pscore = mod10(p_sum);
      eval_res.dscore = mod10(d_sum);
      eval_res.pwin  = (eval_res.pscore >= eval_res.dscore);
      eval_res.dwin  = (eval_res.dscore >= eval_res.pscore);
      eval_res.bad   = (ranks[0] == RANK_ILLEGAL) || (ranks[1] == RANK_ILLEGAL)
                    || (ranks[2] == RANK_ILLEGAL) || (ranks[3] == RANK_ILLEGAL)
                    || (ranks[4] == RANK_ILLEGAL) || (ranks[5] == RANK_ILLEGAL);
      // With no cards on show LEDR winner lights are dark; that blank tie is legal.
      eval_res.mismatch = !eval_res.bad &&
                          ((eval_res.pscore != snap_ledr[3:0]) ||
                           (eval_res.dscore != snap_ledr[7:4]) ||
                           (!all_blank &&
                            ({eval_res.dwin, eval_res.pwin} != snap_ledr[9:8])));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      res_d   = res_q;
      valid_d = 1'b0;
      case (state_q)
         ST_SETTLE: begin
            snap_d = in_vec;
            if (changed) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_EVAL;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_EVAL: begin
            res_d   = eval_res;
            valid_d = 1'b1;
            state_d = ST_HOLD;
         end
         ST_HOLD: begin
            // Capture the new inputs on the way out so the settle count starts now.
            snap_d = in_vec;
            if (changed) begin
               cnt_d   = '0;
               state_d = ST_SETTLE;
            end
         end
         default: state_d = ST_SETTLE;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q <= ST_SETTLE;
         cnt_q   <= '0;
         snap_q  <= '0;
         res_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         res_q   <= res_d;
         valid_q <= valid_d;
      end
   end

   assign p_card1        = res_q.cards[0];
   assign p_card2        = res_q.cards[1];
   assign p_card3        = res_q.cards[2];
   assign d_card1        = res_q.cards[3];
   assign d_card2        = res_q.cards[4];
   assign d_card3        = res_q.cards[5];
   assign player_score   = res_q.pscore;
   assign dealer_score   = res_q.dscore;
   assign player_win     = res_q.pwin;
   assign dealer_win     = res_q.dwin;
   assign bad_pattern    = res_q.bad;
   assign score_mismatch = res_q.mismatch;
   assign result_valid   = valid_q;

`ifdef HEX_MONITOR_COUNT_EN
   logic [7:0] hand_cnt_q, hand_cnt_d;
   logic [7:0] mis_cnt_q, mis_cnt_d;

   always_comb begin
      hand_cnt_d = hand_cnt_q;
      mis_cnt_d  = mis_cnt_q;
      if (state_q == ST_EVAL) begin
         if (hand_cnt_q != '1) begin
            hand_cnt_d = hand_cnt_q + 8'd1;
         end
         if (eval_res.mismatch && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         hand_cnt_q <= '0;
         mis_cnt_q  <= '0;
      end else begin
         hand_cnt_q <= hand_cnt_d;
         mis_cnt_q  <= mis_cnt_d;
      end
   end

   assign hand_count     = hand_cnt_q;
   assign mismatch_count = mis_cnt_q;
`else
   assign hand_count     = '0;
   assign mismatch_count = '0;
`endif

endmodule

// File: tb/tb_hex_card_monitor.sv
// Directed vector bench for hex_card_monitor: decode table, latency, toggling
// inputs and reset during evaluation.
module tb_hex_card_monitor;

   localparam int unsigned S = 4;

   localparam logic [6:0] P_BL = 7'b1111111;
   localparam logic [6:0] P_A  = 7'b0001000;
   localparam logic [6:0] P_2  = 7'b0100100;
   localparam logic [6:0] P_3  = 7'b0110000;
   localparam logic [6:0] P_4  = 7'b0011001;
   localparam logic [6:0] P_5  = 7'b0010010;
   localparam logic [6:0] P_6  = 7'b0000010;
   localparam logic [6:0] P_7  = 7'b1111000;
   localparam logic [6:0] P_8  = 7'b0000000;
   localparam logic [6:0] P_9  = 7'b0010000;
   localparam logic [6:0] P_10 = 7'b1000000;
   localparam logic [6:0] P_J  = 7'b1100001;
   localparam logic [6:0] P_Q  = 7'b0011000;
   localparam logic [6:0] P_K  = 7'b1001001;
   localparam logic [6:0] P_XX = 7'b0101010;

   typedef struct {
      logic [5:0][6:0] hex;
      logic [9:0]      ledr;
      logic [5:0][3:0] cards;
      logic [3:0]      ps;
      logic [3:0]      ds;
      logic            pw;
      logic            dw;
      logic            bad;
      logic            mis;
   } vec_t;

   logic            clk = 1'b0;
   logic            reset;
   logic [5:0][6:0] hex;
   logic [9:0]      ledr;
   logic [3:0]      p_card1, p_card2, p_card3, d_card1, d_card2, d_card3;
   logic [3:0]      player_score, dealer_score;
   logic            player_win, dealer_win, result_valid, bad_pattern, score_mismatch;
   logic [7:0]      hand_count, mismatch_count;

   int unsigned total = 0;
   int unsigned passed = 0;
   int unsigned exp_hand = 0;
   int unsigned exp_mis = 0;
   vec_t        vecs [8];

   always #5 clk = ~clk;

   hex_card_monitor #(.STABLE_CYCLES(S)) dut (
      .CLOCK_50       (clk),
      .reset          (reset),
      .HEX0           (hex[0]),
      .HEX1           (hex[1]),
      .HEX2           (hex[2]),
      .HEX3           (hex[3]),
      .HEX4           (hex[4]),
      .HEX5           (hex[5]),
      .LEDR           (ledr),
      .p_card1        (p_card1),
      .p_card2        (p_card2),
      .p_card3        (p_card3),
      .d_card1        (d_card1),
      .d_card2        (d_card2),
      .d_card3        (d_card3),
      .player_score   (player_score),
      .dealer_score   (dealer_score),
      .player_win     (player_win),
      .dealer_win     (dealer_win),
      .result_valid   (result_valid),
      .bad_pattern    (bad_pattern),
      .score_mismatch (score_mismatch),
      .hand_count     (hand_count),
      .mismatch_count (mismatch_count)
   );

   function automatic vec_t mk(input logic [6:0] h0, h1, h2, h3, h4, h5,
                               input logic [9:0] l,
                               input logic [3:0] c0, c1, c2, c3, c4, c5,
                               input logic [3:0] ps, ds,
                               input logic pw, dw, bad, mis);
      vec_t v;
      v.hex   = {h5, h4, h3, h2, h1, h0};
      v.ledr  = l;
      v.cards = {c5, c4, c3, c2, c1, c0};
      v.ps    = ps;
      v.ds    = ds;
      v.pw    = pw;
      v.dw    = dw;
      v.bad   = bad;
      v.mis   = mis;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) begin
         passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_counters(input string tag);
`ifdef HEX_MONITOR_COUNT_EN
      check({tag, "_hand_count"}, 32'(hand_count), exp_hand);
      check({tag, "_mismatch_count"}, 32'(mismatch_count), exp_mis);
`else
      check({tag, "_counters_zero"}, {16'd0, hand_count, mismatch_count}, 32'd0);
`endif
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_cards"},
            {8'd0, d_card3, d_card2, d_card1, p_card3, p_card2, p_card1}, 32'd0);
      check({tag, "_scores_flags"},
            {player_score, dealer_score, player_win, dealer_win, result_valid,
             bad_pattern, score_mismatch}, 32'd0);
      check_counters(tag);
   endtask

   // Called at the negedge just after the inputs were driven.
   task automatic expect_pulse(input vec_t v, input string tag);
      logic early;
      early = 1'b0;
      repeat (S + 1) begin
         @(negedge clk);
         if (result_valid) early = 1'b1;
      end
      @(negedge clk);
      if (exp_hand < 255) exp_hand++;
      if (v.mis && exp_mis < 255) exp_mis++;
      check({tag, "_latency"}, {30'd0, early, result_valid}, 32'd1);
      check({tag, "_cards"},
            {8'd0, d_card3, d_card2, d_card1, p_card3, p_card2, p_card1},
            {8'd0, v.cards});
      check({tag, "_scores"}, {24'd0, player_score, dealer_score}, {24'd0, v.ps, v.ds});
      check({tag, "_flags"},
            {28'd0, player_win, dealer_win, bad_pattern, score_mismatch},
            {28'd0, v.pw, v.dw, v.bad, v.mis});
      check_counters(tag);
      @(negedge clk);
      check({tag, "_single_pulse"}, {31'd0, result_valid}, 32'd0);
   endtask

   task automatic drive(input vec_t v);
      hex  = v.hex;
      ledr = v.ledr;
   endtask

   initial begin
      vecs[0] = mk(P_A, P_5, P_BL, P_3, P_7, P_9, 10'b10_1001_0110,
                   1, 5, 0, 3, 7, 9, 6, 9, 0, 1, 0, 0);
      vecs[1] = mk(P_A, P_5, P_BL, P_3, P_7, P_9, 10'b10_1000_0110,
                   1, 5, 0, 3, 7, 9, 6, 9, 0, 1, 0, 1);
      vecs[2] = mk(P_A, P_5, P_XX, P_3, P_7, P_9, 10'b10_1001_0110,
                   1, 5, 15, 3, 7, 9, 6, 9, 0, 1, 1, 0);
      vecs[3] = mk(P_K, P_Q, P_BL, P_10, P_J, P_BL, 10'b11_0000_0000,
                   13, 12, 0, 10, 11, 0, 0, 0, 1, 1, 0, 0);
      vecs[4] = mk(P_2, P_4, P_6, P_8, P_8, P_K, 10'b10_0110_0010,
                   2, 4, 6, 8, 8, 13, 2, 6, 0, 1, 0, 0);
      vecs[5] = mk(P_9, P_9, P_9, P_10, P_A, P_2, 10'b01_0011_0111,
                   9, 9, 9, 10, 1, 2, 7, 3, 1, 0, 0, 0);
      vecs[6] = mk(P_BL, P_BL, P_BL, P_BL, P_BL, P_BL, 10'b00_0000_0000,
                   0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      vecs[7] = mk(P_2, P_3, P_4, P_5, P_6, P_Q, 10'b10_0001_1001,
                   2, 3, 4, 5, 6, 12, 9, 1, 1, 0, 0, 1);

      reset = 1'b1;
      hex   = {6{P_BL}};
      ledr  = '0;
      repeat (3) @(negedge clk);
      check_zero("reset");
      reset = 1'b0;

      for (int i = 0; i < 8; i++) begin
         drive(vecs[i]);
         expect_pulse(vecs[i], $sformatf("v%0d", i));
      end

      // Inputs toggling faster than the settle window never publish.
      begin
         logic seen;
         seen = 1'b0;
         for (int t = 0; t < 6; t++) begin
            drive((t % 2 == 0) ? vecs[0] : vecs[5]);
            repeat (2) begin
               @(negedge clk);
               if (result_valid) seen = 1'b1;
            end
         end
         check("toggle_no_pulse", {31'd0, seen}, 32'd0);
         drive(vecs[0]);
         expect_pulse(vecs[0], "toggle_hold");
      end

      // Reset landing on the EVAL cycle.
      drive(vecs[1]);
      repeat (S + 1) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      exp_hand = 0;
      exp_mis  = 0;
      check_zero("reset_eval");
      reset = 1'b0;
      expect_pulse(vecs[1], "post_reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/hex_card_monitor.md
Name: hex_card_monitor

Overview:
- Reads the six seven-segment card displays and the LEDR score/winner lights that the baccarat top level drives.
- Decodes each display back to a card rank and recomputes both hand scores and the winner.
- Waits until the displays have been stable for a set number of cycles, then flags any disagreement with LEDR.
- Serves as the decoding end of the card-display interface, for bench self-checking and on-board diagnostics. It lives alongside the baccarat datapath and never drives it.

Parameters:
- STABLE_CYCLES, 4: consecutive unchanged samples required before a hand is evaluated; legal range 1..255.

Ports:
- CLOCK_50  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- HEX0, HEX1, HEX2  in  7 each  player cards 1..3, active-low segments, bit6..0 = g..a.
- HEX3, HEX4, HEX5  in  7 each  dealer cards 1..3, same encoding.
- LEDR  in  10  [3:0] player score, [7:4] dealer score, [8] player wins, [9] dealer wins.
- p_card1, p_card2, p_card3, d_card1, d_card2, d_card3  out  4 each  decoded rank: 0 = blank, 1..13 = A..K, 15 = illegal.
- player_score, dealer_score  out  4 each  recomputed score, 0..9.
- player_win, dealer_win  out  1 each  recomputed winner; a tie sets both.
- result_valid  out  1  one-cycle pulse when a new evaluation is published.
- bad_pattern  out  1  at least one display held an undefined pattern.
- score_mismatch  out  1  recomputed scores or winner bits differ from LEDR.
- hand_count, mismatch_count  out  8 each  present only with the optional feature.

Behaviour:
- Decode patterns:
  - blank 1111111 → 0; A 0001000; 2 0100100; 3 0110000; 4 0011001; 5 0010010; 6 0000010.
  - 7 1111000; 8 0000000; 9 0010000; 10 1000000; J 1100001; Q 0011000; K 1001001 → 13 (KING = 7'b0001001 in tb_baccarat).
  - Any other pattern → 15.
- Card value: ranks 1..9 count at face value; ranks 0, 10..13 and 15 count as 0.
- Score arithmetic: sum of the three card values in 5 bits, reduced mod 10 to 4 bits.
- Winner: higher score wins; equal scores set both player_win and dealer_win.
- Snapshot: a register holding {HEX5..HEX0, LEDR} (52 bits), loaded every cycle in the SETTLE state.
- State machine, states SETTLE, EVAL, HOLD:
  - SETTLE:
    - If the inputs differ from the snapshot, stable_cnt clears to 0.
    - Otherwise stable_cnt increments. When it reaches STABLE_CYCLES-1 with no change, go to EVAL next cycle.
  - EVAL (1 cycle):
    - Decode the snapshot and register all card, score, win and flag outputs.
    - Go to HOLD.
  - HOLD:
    - result_valid is high on the first HOLD cycle only.
    - Outputs are held.
    - Any input that differs from the snapshot → SETTLE with stable_cnt = 0. Outputs keep their last values.
- Latency: with the inputs last changing before edge t, result_valid is high in the cycle after edge t+STABLE_CYCLES+1.
- bad_pattern: set if any rank is 15.
- score_mismatch:
  - Forced to 0 whenever bad_pattern is 1.
  - Otherwise 1 if player_score ≠ LEDR[3:0], or dealer_score ≠ LEDR[7:4], or {dealer_win, player_win} ≠ LEDR[9:8].
- All-blank displays with LEDR = 0 are a legal hand: scores 0, tie, no mismatch.
- Inputs that change during EVAL are ignored for the current result. They are caught in HOLD on the next cycle.
- Reset, including mid-evaluation:
  - State goes to SETTLE; stable_cnt and snapshot clear to 0.
  - All outputs clear to 0 (cards 0, scores 0, wins 0, flags 0, result_valid 0).
  - Counters clear to 0.

Optional Feature:
- HEX_MONITOR_COUNT_EN defined:
  - hand_count increments on each result_valid pulse.
  - mismatch_count increments on each result_valid pulse that has score_mismatch = 1.
  - Both counters saturate at 255 and clear only on reset.
- Not defined: no counter flops are built; hand_count and mismatch_count are driven constant 0.

Decomposition:
- Package card_disp_pkg holds:
  - the 14 segment pattern constants (blank, A..K);
  - the card_rank_t 4-bit typedef and the RANK_ILLEGAL = 15 constant;
  - a function card_value(card_rank_t) returning 0..9.
- One combinational sub-module, seg_to_rank (7-bit pattern → card_rank_t), instantiated six times.
- The FSM, score arithmetic and counters stay in hex_card_monitor.

Test Plan:
1. HEX0..5 = A, 5, blank, 3, 7, 9; LEDR = 10_1001_0110, held for 10 cycles → ranks 1, 5, 0, 3, 7, 9; player_score 6, dealer_score 9; dealer_win 1, player_win 0; score_mismatch 0; one result_valid pulse, exactly STABLE_CYCLES+2 cycles after the last change.
2. Same cards with LEDR[7:4] = 1000 → score_mismatch 1; with HEX_MONITOR_COUNT_EN, mismatch_count 1 and hand_count 2 after scenarios 1–2.
3. HEX2 = 0101010 (undefined) → p_card3 15, bad_pattern 1, score_mismatch 0.
4. Inputs toggled every 2 cycles with STABLE_CYCLES = 4 → no result_valid pulse; then inputs held → exactly one pulse.
5. Player K, Q, blank vs dealer 10, J, blank, LEDR = 11_0000_0000 → both scores 0, tie, no mismatch.
6. reset asserted the cycle of EVAL → all outputs 0 the next cycle; no pulse until STABLE_CYCLES+2 cycles after reset releases.
